// File: rtl/cpu_controller_if.sv
// Control bundle between the instruction sequencer and the datapath:
// opcode/zero flow into the sequencer, strobes and debug phase flow out.
interface cpu_controller_if #(
  parameter int OPCODE_WIDTH = 3,
  parameter int PHASE_WIDTH  = 3
);
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    zero;
  logic                    sel;
  logic                    rd;
  logic                    ld_ir;
  logic                    ld_ac;
  logic                    ld_pc;
  logic                    inc_pc;
  logic                    wr;
  logic                    data_e;
  logic                    halt;
  logic [PHASE_WIDTH-1:0]  phase;

  modport master (
    input  opcode, zero,
    output sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, wr, data_e, halt, phase
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, wr, data_e, halt, phase
  );
endinterface

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer: every instruction takes 8 clocks,
// HLT freezes the sequencer in OP_ADDR until reset.
module cpu_controller #(
  parameter int OPCODE_WIDTH = 3,
  parameter int PHASE_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cpu_controller_if.master      bus
);

  typedef enum logic [PHASE_WIDTH-1:0] {
    INST_ADDR, INST_FETCH, INST_LOAD, IDLE,
    OP_ADDR, OP_FETCH, ALU_OP, STORE
  } phase_e;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP
  } opcode_e;

  phase_e  phase_q, phase_d;
  logic    halted_q, halted_d;
  opcode_e op;
  logic    is_aluop;

  logic sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, wr, data_e, halt;

  assign op       = opcode_e'(bus.opcode);
  assign is_aluop = op inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    sel      = 1'b0;
    rd       = 1'b0;
    ld_ir    = 1'b0;
    ld_ac    = 1'b0;
    ld_pc    = 1'b0;
    inc_pc   = 1'b0;
    wr       = 1'b0;
    data_e   = 1'b0;
    halt     = 1'b0;

    if (halted_q) begin
      halt = 1'b1;
    end else begin
      if (phase_q == OP_ADDR && op == OP_HLT) halted_d = 1'b1;
      else phase_d = phase_e'(phase_q + PHASE_WIDTH'(1));

      case (phase_q)
        INST_ADDR:  sel = 1'b1;
        INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR:  inc_pc = 1'b1;
        OP_FETCH: rd = is_aluop;
        ALU_OP: begin
          rd     = is_aluop;
          inc_pc = (op == OP_SKZ) && bus.zero;
          ld_pc  = (op == OP_JMP);
          data_e = (op == OP_STO);
        end
        STORE: begin
          rd     = is_aluop;
          ld_ac  = is_aluop;
          ld_pc  = (op == OP_JMP);
          wr     = (op == OP_STO);
          data_e = (op == OP_STO);
        end
        default: ;
      endcase
    end
  end

  assign bus.sel    = sel;
  assign bus.rd     = rd;
  assign bus.ld_ir  = ld_ir;
  assign bus.ld_ac  = ld_ac;
  assign bus.ld_pc  = ld_pc;
  assign bus.inc_pc = inc_pc;
  assign bus.wr     = wr;
  assign bus.data_e = data_e;
  assign bus.halt   = halt;
  assign bus.phase  = phase_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed scenarios plus randomized
// instruction streams compared against a behavioural instruction-cycle model.
module tb_cpu_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_compared = 0;
  int   n_mismatched = 0;

  // Reference model state: cycle position within the instruction and halt flag.
  int m_ph = 0;
  bit m_h = 1'b0;

  cpu_controller_if bus ();

  cpu_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Expected {sel,rd,ld_ir,ld_ac,ld_pc,inc_pc,wr,data_e,halt,phase[2:0]}.
  function automatic logic [11:0] expect_out(input int ph, input bit h,
                                             input int op, input bit z);
    bit aluop = (op >= 2 && op <= 5);
    logic [2:0] p3;
    logic [8:0] s;
    if (h) return {9'b0_0000_0001, 3'd4};
    p3 = ph[2:0];
    s[8] = (ph < 4);
    s[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && aluop);
    s[6] = (ph == 2 || ph == 3);
    s[5] = (ph == 7 && aluop);
    s[4] = (ph >= 6 && op == 7);
    s[3] = (ph == 4) || (ph == 6 && op == 1 && z);
    s[2] = (ph == 7 && op == 6);
    s[1] = (ph >= 6 && op == 6);
    s[0] = 1'b0;
    return {s, p3};
  endfunction

  function automatic logic [11:0] observed();
    return {bus.sel, bus.rd, bus.ld_ir, bus.ld_ac, bus.ld_pc, bus.inc_pc,
            bus.wr, bus.data_e, bus.halt, bus.phase};
  endfunction

  task automatic check(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed %b expected %b (model phase %0d halted %0d)",
             tag, obs, exp, m_ph, m_h);
    end
  endtask

  // One clock: drive inputs at negedge, check outputs, advance model at posedge.
  task automatic cycle(input string tag, input int op, input bit z, input bit rst);
    logic [11:0] o;
    @(negedge clk);
    bus.opcode = 3'(op);
    bus.zero   = z;
    rst_n      = ~rst;
    #1;
    o = observed();
    check(tag, o, expect_out(m_ph, m_h, op, z));
    check("rd_wr_excl", {11'd0, o[10] & o[5]}, 12'd0);
    check("ldpc_incpc_excl", {11'd0, o[7] & o[6]}, 12'd0);
    @(posedge clk);
    if (rst) begin
      m_ph = 0;
      m_h  = 1'b0;
    end else if (!m_h) begin
      if (m_ph == 4 && op == 0) m_h = 1'b1;
      else m_ph = (m_ph + 1) % 8;
    end
  endtask

  // One instruction; opcode is garbage during fetch phases since it must be ignored.
  task automatic run_instr(input string tag, input int op, input bit z);
    for (int i = 0; i < 8; i++) begin
      if (m_ph < 4) cycle(tag, int'($urandom_range(0, 7)), z, 1'b0);
      else          cycle(tag, op, z, 1'b0);
    end
  endtask

  initial begin
    int op;
    bus.opcode = 3'd0;
    bus.zero   = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    m_ph = 0;
    m_h  = 1'b0;

    // Reset state, checked while reset is still asserted.
    cycle("reset_state", 2, 1'b0, 1'b1);

    for (int k = 0; k < 2; k++) run_instr("add", 2, 1'b0);
    run_instr("sto", 6, 1'b0);
    run_instr("skz_z1", 1, 1'b1);
    run_instr("skz_z0", 1, 1'b0);
    run_instr("jmp", 7, 1'b1);
    run_instr("lda", 5, 1'b0);
    run_instr("and", 3, 1'b1);
    run_instr("xor", 4, 1'b0);

    // HLT: reach OP_ADDR, then 20 frozen clocks, then one reset edge.
    while (m_ph != 4) cycle("pre_hlt", int'($urandom_range(0, 7)), 1'b0, 1'b0);
    cycle("hlt_op_addr", 0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      cycle("halted", int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
    cycle("halt_reset", 2, 1'b1, 1'b1);
    cycle("after_halt_reset", 2, 1'b0, 1'b0);

    // Abort an ADD in OP_FETCH.
    while (m_ph != 5) cycle("pre_abort", 2, 1'b0, 1'b0);
    cycle("abort_reset", 2, 1'b0, 1'b1);
    run_instr("after_abort", 2, 1'b0);

    // Randomized stream, including HLT and occasional resets.
    op = 2;
    for (int i = 0; i < 400; i++) begin
      bit r;
      if (m_ph == 0) op = int'($urandom_range(0, 7));
      r = ($urandom_range(0, 39) == 0) || (m_h && $urandom_range(0, 7) == 0);
      cycle("random", (m_ph < 4) ? int'($urandom_range(0, 7)) : op,
            1'($urandom_range(0, 1)), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
